// File: rtl/sha_nonce_sequencer_if.sv
// Handshake between the nonce sequencer (master) and the SHA computational block (slave).
interface sha_nonce_sequencer_if #(
    parameter int unsigned TOTAL_SIZE = 640
) ();
    logic [TOTAL_SIZE-1:0] inputMsg;
    logic                  beginComputation;
    logic                  computationComplete;
    logic [255:0]          SHAoutput;

    modport master (
        output inputMsg,
        output beginComputation,
        input  computationComplete,
        input  SHAoutput
    );

    modport slave (
        input  inputMsg,
        input  beginComputation,
        output computationComplete,
        output SHAoutput
    );
endinterface

// File: rtl/sha_nonce_sequencer.sv
// Walks a nonce range through the SHA block, one message at a time, until a hash
// falls below the latched target or the range runs out.
module sha_nonce_sequencer #(
    parameter int unsigned TOTAL_SIZE  = 640,
    parameter int unsigned NONCE_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [TOTAL_SIZE-NONCE_WIDTH-1:0] headerIn,
    input  logic [NONCE_WIDTH-1:0]            nonceStart,
    input  logic [NONCE_WIDTH-1:0]            nonceEnd,
    input  logic [255:0]                      target,
    sha_nonce_sequencer_if.master             sha,
    output logic                              busy,
    output logic                              found,
    output logic                              exhausted,
    output logic [NONCE_WIDTH-1:0]            foundNonce,
    output logic [255:0]                      foundHash,
    output logic [31:0]                       hashCount
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        DRAIN
    } state_t;

    state_t                              state_q, state_d;
    logic [TOTAL_SIZE-NONCE_WIDTH-1:0]   header_q, header_d;
    logic [255:0]                        target_q, target_d;
    logic [NONCE_WIDTH-1:0]              end_q, end_d;
    logic [NONCE_WIDTH-1:0]              nonce_q, nonce_d;
    logic [255:0]                        hash_q, hash_d;
    logic                                found_q, found_d;
    logic                                exhausted_q, exhausted_d;
    logic [NONCE_WIDTH-1:0]              found_nonce_q, found_nonce_d;
    logic [255:0]                        found_hash_q, found_hash_d;
    logic [31:0]                         count_q, count_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            header_q      <= '0;
            target_q      <= '0;
            end_q         <= '0;
            nonce_q       <= '0;
            hash_q        <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            header_q      <= header_d;
            target_q      <= target_d;
            end_q         <= end_d;
            nonce_q       <= nonce_d;
            hash_q        <= hash_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
            count_q       <= count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        header_d      = header_q;
        target_d      = target_q;
        end_d         = end_q;
        nonce_d       = nonce_q;
        hash_d        = hash_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        count_d       = count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    header_d    = headerIn;
                    target_d    = target;
                    end_d       = nonceEnd;
                    nonce_d     = nonceStart;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    count_d     = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = abort ? IDLE : WAIT;
            end
            WAIT: begin
                // Abort coinciding with the done pulse consumes it, so no drain is needed.
                if (abort) begin
                    state_d = sha.computationComplete ? IDLE : DRAIN;
                end else if (sha.computationComplete) begin
                    hash_d  = sha.SHAoutput;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (count_q != '1) begin
                    count_d = count_q + 32'd1;
                end
                if (abort) begin
                    state_d = IDLE;
                end else if (hash_q < target_q) begin
                    found_d       = 1'b1;
                    found_nonce_d = nonce_q;
                    found_hash_d  = hash_q;
                    state_d       = IDLE;
                end else if (nonce_q == end_q) begin
                    exhausted_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    nonce_d = nonce_q + 1'b1;
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if (sha.computationComplete) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sha.beginComputation = (state_q == ISSUE);
        sha.inputMsg         = {header_q, nonce_q};
        busy                 = (state_q != IDLE);
        found                = found_q;
        exhausted            = exhausted_q;
        foundNonce           = found_nonce_q;
        foundHash            = found_hash_q;
        hashCount            = count_q;
    end

endmodule

// File: tb/tb_sha_nonce_sequencer.sv
// Directed bench for sha_nonce_sequencer against a fixed-latency stub SHA block
// whose hash is 1000 - nonce.
module tb_sha_nonce_sequencer;

    localparam int unsigned TOTAL_SIZE  = 640;
    localparam int unsigned NONCE_WIDTH = 32;
    localparam int unsigned HDR_W       = TOTAL_SIZE - NONCE_WIDTH;
    localparam int unsigned LAT         = 140;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [HDR_W-1:0]  headerIn = '0;
    logic [31:0]       nonceStart = '0;
    logic [31:0]       nonceEnd = '0;
    logic [255:0]      target = '0;
    logic              busy, found, exhausted;
    logic [31:0]       foundNonce;
    logic [255:0]      foundHash;
    logic [31:0]       hashCount;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0]  pulses[$];
    logic         saw_cc;
    logic [HDR_W-1:0] hdr_a, hdr_b;

    sha_nonce_sequencer_if #(.TOTAL_SIZE(TOTAL_SIZE)) sha_if ();

    sha_nonce_sequencer #(
        .TOTAL_SIZE (TOTAL_SIZE),
        .NONCE_WIDTH(NONCE_WIDTH)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .abort     (abort),
        .headerIn  (headerIn),
        .nonceStart(nonceStart),
        .nonceEnd  (nonceEnd),
        .target    (target),
        .sha       (sha_if),
        .busy      (busy),
        .found     (found),
        .exhausted (exhausted),
        .foundNonce(foundNonce),
        .foundHash (foundHash),
        .hashCount (hashCount)
    );

    always #5 clk = ~clk;

    // Stub SHA block, shares n_rst with the sequencer.
    int unsigned stub_cnt;
    logic [31:0] stub_nonce;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stub_cnt                   <= 0;
            stub_nonce                 <= '0;
            sha_if.computationComplete <= 1'b0;
            sha_if.SHAoutput           <= '0;
        end else begin
            sha_if.computationComplete <= 1'b0;
            if (sha_if.beginComputation) begin
                stub_cnt   <= LAT - 1;
                stub_nonce <= sha_if.inputMsg[31:0];
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) begin
                    sha_if.computationComplete <= 1'b1;
                    sha_if.SHAoutput           <= 256'd1000 - {224'd0, stub_nonce};
                end
            end
        end
    end

    always @(negedge clk) begin
        if (sha_if.beginComputation) pulses.push_back(sha_if.inputMsg[31:0]);
    end

    task automatic check(input string tag, input logic [TOTAL_SIZE-1:0] got,
                         input logic [TOTAL_SIZE-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [HDR_W-1:0] hdr, input logic [31:0] ns,
                          input logic [31:0] ne, input logic [255:0] tgt);
        @(negedge clk);
        pulses.delete();
        headerIn   = hdr;
        nonceStart = ns;
        nonceEnd   = ne;
        target     = tgt;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", {639'd0, busy}, '0);
    endtask

    task automatic wait_pulse(input int unsigned budget);
        int unsigned n = 0;
        while (!sha_if.beginComputation && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("pulse_within_budget", {639'd0, sha_if.beginComputation}, 640'd1);
    endtask

    initial begin
        hdr_a = {19{32'hDEADBEEF}};
        hdr_b = {19{32'h12345678}};

        repeat (3) @(negedge clk);
        check("rst_busy",      {639'd0, busy}, '0);
        check("rst_msg",       sha_if.inputMsg, '0);
        check("rst_begin",     {639'd0, sha_if.beginComputation}, '0);
        check("rst_count",     {608'd0, hashCount}, '0);
        n_rst = 1'b1;

        // Job 1: success at nonce 6, plus start-to-pulse timing and header latching.
        @(negedge clk);
        pulses.delete();
        headerIn = hdr_a; nonceStart = 32'd0; nonceEnd = 32'd100; target = 256'd995;
        start = 1'b1;
        @(negedge clk);
        check("t1_pulse_t1", {639'd0, sha_if.beginComputation}, 640'd1);
        start    = 1'b0;
        headerIn = hdr_b;
        @(negedge clk);
        check("t1_pulse_t2", {639'd0, sha_if.beginComputation}, '0);
        check("t1_header",   {32'd0, sha_if.inputMsg[TOTAL_SIZE-1:32]}, {32'd0, hdr_a});
        wait_idle(2000);
        check("t1_found",     {639'd0, found}, 640'd1);
        check("t1_exhausted", {639'd0, exhausted}, '0);
        check("t1_nonce",     {608'd0, foundNonce}, 640'd6);
        check("t1_hash",      {384'd0, foundHash}, 640'd994);
        check("t1_count",     {608'd0, hashCount}, 640'd7);
        check("t1_pulses",    pulses.size(), 640'd7);

        // Job 2: target 0 exhausts 5..7.
        launch(hdr_a, 32'd5, 32'd7, 256'd0);
        wait_idle(1000);
        check("t2_found",     {639'd0, found}, '0);
        check("t2_exhausted", {639'd0, exhausted}, 640'd1);
        check("t2_count",     {608'd0, hashCount}, 640'd3);
        check("t2_pulses",    pulses.size(), 640'd3);
        for (int i = 0; i < 3 && i < pulses.size(); i++)
            check("t2_nonce_seq", {608'd0, pulses[i]}, 640'd5 + 640'(i));

        // Job 3: wrapping range FFFFFFFE..1.
        launch(hdr_b, 32'hFFFF_FFFE, 32'h0000_0001, 256'd0);
        wait_idle(1000);
        check("t3_exhausted", {639'd0, exhausted}, 640'd1);
        check("t3_count",     {608'd0, hashCount}, 640'd4);
        check("t3_pulses",    pulses.size(), 640'd4);
        if (pulses.size() == 4) begin
            check("t3_n0", {608'd0, pulses[0]}, {608'd0, 32'hFFFF_FFFE});
            check("t3_n1", {608'd0, pulses[1]}, {608'd0, 32'hFFFF_FFFF});
            check("t3_n2", {608'd0, pulses[2]}, 640'd0);
            check("t3_n3", {608'd0, pulses[3]}, 640'd1);
        end

        // Job 4: abort mid-WAIT drains the outstanding pulse; start during DRAIN ignored.
        launch(hdr_a, 32'd10, 32'd20, 256'd0);
        repeat (50) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b1;
        check("t4_busy_drain", {639'd0, busy}, 640'd1);
        @(negedge clk);
        start  = 1'b0;
        saw_cc = 1'b0;
        for (int n = 0; n < 400 && busy; n++) begin
            if (sha_if.computationComplete) saw_cc = 1'b1;
            @(negedge clk);
        end
        check("t4_idle",      {639'd0, busy}, '0);
        check("t4_drained",   {639'd0, saw_cc}, 640'd1);
        check("t4_pulses",    pulses.size(), 640'd1);
        check("t4_count",     {608'd0, hashCount}, '0);
        check("t4_exhausted", {639'd0, exhausted}, '0);
        repeat (5) @(negedge clk);
        check("t4_no_restart", {639'd0, busy}, '0);
        launch(hdr_a, 32'd0, 32'd100, 256'd995);
        wait_idle(2000);
        check("t4_clean_found", {639'd0, found}, 640'd1);
        check("t4_clean_nonce", {608'd0, foundNonce}, 640'd6);
        check("t4_clean_count", {608'd0, hashCount}, 640'd7);

        // Job 5: reset mid-WAIT, then a single-nonce job.
        launch(hdr_b, 32'd0, 32'd5, 256'd0);
        repeat (30) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("t5_busy",      {639'd0, busy}, '0);
        check("t5_found",     {639'd0, found}, '0);
        check("t5_fnonce",    {608'd0, foundNonce}, '0);
        check("t5_fhash",     {384'd0, foundHash}, '0);
        check("t5_count",     {608'd0, hashCount}, '0);
        check("t5_msg",       sha_if.inputMsg, '0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        launch(hdr_a, 32'd3, 32'd3, 256'd0);
        wait_idle(1000);
        check("t5_single_count", {608'd0, hashCount}, 640'd1);
        check("t5_single_exh",   {639'd0, exhausted}, 640'd1);
        check("t5_single_found", {639'd0, found}, '0);
        check("t5_single_pulse", pulses.size(), 640'd1);
        if (pulses.size() == 1)
            check("t5_single_nonce", {608'd0, pulses[0]}, 640'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
